// File: rtl/hw2_result_collector.sv
// rtl/hw2_result_collector.sv - checks (a+/-b)*c results and reports per-frame totals
module hw2_result_collector #(
  parameter int WIDTH     = 8,
  parameter int FRAME_LEN = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [WIDTH-1:0]     c,
  input  logic                 s,
  input  logic [2*WIDTH-1:0]   d,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [7:0]           out_count,
  output logic [2*WIDTH+7:0]   out_sum,
  output logic [7:0]           out_err_cnt,
  output logic [7:0]           out_first_err,
  output logic                 busy
);

  localparam int RW = 2 * WIDTH;
  localparam int SW = 2 * WIDTH + 8;
  localparam logic [7:0] LP_FRAME = 8'(FRAME_LEN);
  localparam logic [7:0] LP_NONE  = 8'hFF;

  typedef enum logic [1:0] {IDLE, COLLECT, REPORT} state_t;

  state_t          r_state;
  logic [7:0]      r_count;
  logic [SW-1:0]   r_sum;
  logic [7:0]      r_err_cnt;
  logic [7:0]      r_first_err;

  logic [RW-1:0]   w_a_ext;
  logic [RW-1:0]   w_b_ext;
  logic [RW-1:0]   w_c_ext;
  logic [RW-1:0]   w_ab;
  logic [RW-1:0]   w_expected;
  logic            w_accept;
  logic            w_mismatch;
  logic [7:0]      w_count_nxt;
  logic [SW-1:0]   w_sum_nxt;
  logic [7:0]      w_err_nxt;
  logic [7:0]      w_first_nxt;
  logic            w_close;

  // Reference model of the upstream datapath, computed at the result width
  always_comb begin
    w_a_ext    = {{WIDTH{1'b0}}, a};
    w_b_ext    = {{WIDTH{1'b0}}, b};
    w_c_ext    = {{WIDTH{1'b0}}, c};
    w_ab       = s ? (w_a_ext + w_b_ext) : (w_a_ext - w_b_ext);
    w_expected = w_ab * w_c_ext;
  end

  assign in_ready = (r_state != REPORT);
  assign busy     = (r_state != IDLE);
  assign w_accept = in_valid && in_ready;

  // Frame totals as they would stand after this cycle's accept (if any)
  always_comb begin
    w_mismatch  = w_accept && (d != w_expected);
    w_count_nxt = w_accept ? (r_count + 8'd1) : r_count;
    w_sum_nxt   = w_accept ? (r_sum + {8'd0, d}) : r_sum;
    w_err_nxt   = w_mismatch ? (r_err_cnt + 8'd1) : r_err_cnt;
    w_first_nxt = (w_mismatch && (r_err_cnt == 8'd0)) ? r_count : r_first_err;
    w_close     = 1'b0;
    if (r_state == IDLE)
      w_close = w_accept && (w_count_nxt == LP_FRAME);
    else if (r_state == COLLECT)
      w_close = flush || (w_accept && (w_count_nxt == LP_FRAME));
  end

  // Frame FSM: accumulate, snapshot totals into the report registers on close
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_count       <= 8'd0;
      r_sum         <= '0;
      r_err_cnt     <= 8'd0;
      r_first_err   <= LP_NONE;
      out_valid     <= 1'b0;
      out_count     <= 8'd0;
      out_sum       <= '0;
      out_err_cnt   <= 8'd0;
      out_first_err <= LP_NONE;
    end else begin
      case (r_state)
        IDLE, COLLECT: begin
          r_count     <= w_count_nxt;
          r_sum       <= w_sum_nxt;
          r_err_cnt   <= w_err_nxt;
          r_first_err <= w_first_nxt;
          if (w_close) begin
            r_state       <= REPORT;
            out_valid     <= 1'b1;
            out_count     <= w_count_nxt;
            out_sum       <= w_sum_nxt;
            out_err_cnt   <= w_err_nxt;
            out_first_err <= w_first_nxt;
          end else if (w_accept) begin
            r_state <= COLLECT;
          end
        end
        REPORT: begin
          if (out_ready) begin
            r_state     <= IDLE;
            out_valid   <= 1'b0;
            r_count     <= 8'd0;
            r_sum       <= '0;
            r_err_cnt   <= 8'd0;
            r_first_err <= LP_NONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hw2_result_collector.sv
// tb/tb_hw2_result_collector.sv - directed self-checking bench for hw2_result_collector
module tb_hw2_result_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a, b, c;
  logic        s;
  logic [15:0] d;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_count;
  logic [23:0] out_sum;
  logic [7:0]  out_err_cnt;
  logic [7:0]  out_first_err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  hw2_result_collector #(.WIDTH(8), .FRAME_LEN(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .s(s), .d(d), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count),
    .out_sum(out_sum), .out_err_cnt(out_err_cnt), .out_first_err(out_first_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] ia, input logic [7:0] ib, input logic [7:0] ic,
                      input logic is, input logic [15:0] id, input logic ifl);
    a = ia; b = ib; c = ic; s = is; d = id; flush = ifl; in_valid = 1'b1;
    step();
    in_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; a = '0; b = '0; c = '0; s = 1'b0; d = '0;
    flush = 1'b0; out_ready = 1'b0;
    step();
    step();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_first_err", out_first_err, 8'hFF);
    chk("rst_out_count", out_count, 0);
    chk("rst_out_sum", out_sum, 0);
    rst = 1'b1;

    // clean frame
    send(8'd3, 8'd5, 8'd7, 1'b1, 16'd56, 1'b0);
    chk("clean_busy_after_first", busy, 1);
    send(8'd10, 8'd4, 8'd2, 1'b0, 16'd12, 1'b0);
    send(8'd0, 8'd1, 8'd1, 1'b0, 16'd65535, 1'b0);
    chk("clean_no_early_report", out_valid, 0);
    send(8'd255, 8'd255, 8'd255, 1'b1, 16'd64514, 1'b0);
    chk("clean_out_valid", out_valid, 1);
    chk("clean_count", out_count, 4);
    chk("clean_sum", out_sum, 130117);
    chk("clean_err_cnt", out_err_cnt, 0);
    chk("clean_first_err", out_first_err, 255);

    // backpressure: inputs offered during REPORT must be ignored
    a = 8'd1; b = 8'd1; c = 8'd1; s = 1'b1; d = 16'd9; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_count", out_count, 4);
      chk("bp_sum", out_sum, 130117);
      chk("bp_first_err", out_first_err, 255);
    end
    in_valid = 1'b0;
    handshake();
    chk("hs_out_valid", out_valid, 0);
    chk("hs_busy", busy, 0);
    chk("hs_in_ready", in_ready, 1);

    // mismatch frame at index 1; count restarts from 0
    send(8'd3, 8'd5, 8'd7, 1'b1, 16'd56, 1'b0);
    send(8'd10, 8'd4, 8'd2, 1'b0, 16'd13, 1'b0);
    send(8'd0, 8'd1, 8'd1, 1'b0, 16'd65535, 1'b0);
    send(8'd255, 8'd255, 8'd255, 1'b1, 16'd64514, 1'b0);
    chk("mis_out_valid", out_valid, 1);
    chk("mis_count", out_count, 4);
    chk("mis_err_cnt", out_err_cnt, 1);
    chk("mis_first_err", out_first_err, 1);
    chk("mis_sum", out_sum, 130118);
    handshake();

    // flush concurrent with the third accept
    send(8'd3, 8'd5, 8'd7, 1'b1, 16'd56, 1'b0);
    send(8'd10, 8'd4, 8'd2, 1'b0, 16'd12, 1'b0);
    send(8'd0, 8'd1, 8'd1, 1'b0, 16'd65535, 1'b1);
    chk("flush_out_valid", out_valid, 1);
    chk("flush_count", out_count, 3);
    chk("flush_sum", out_sum, 65603);
    chk("flush_err_cnt", out_err_cnt, 0);
    handshake();

    // flush in IDLE is ignored
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    chk("idle_flush_out_valid", out_valid, 0);
    chk("idle_flush_busy", busy, 0);

    // reset mid-frame discards the partial frame
    send(8'd3, 8'd5, 8'd7, 1'b1, 16'd1, 1'b0);
    send(8'd10, 8'd4, 8'd2, 1'b0, 16'd2, 1'b0);
    send(8'd0, 8'd1, 8'd1, 1'b0, 16'd3, 1'b0);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 1);
    send(8'd3, 8'd5, 8'd7, 1'b1, 16'd56, 1'b0);
    send(8'd10, 8'd4, 8'd2, 1'b0, 16'd12, 1'b0);
    send(8'd0, 8'd1, 8'd1, 1'b0, 16'd65535, 1'b0);
    chk("midrst_no_early_report", out_valid, 0);
    send(8'd255, 8'd255, 8'd255, 1'b1, 16'd0, 1'b0);
    chk("post_out_valid", out_valid, 1);
    chk("post_count", out_count, 4);
    chk("post_sum", out_sum, 65603);
    chk("post_err_cnt", out_err_cnt, 1);
    chk("post_first_err", out_first_err, 3);
    handshake();
    chk("post_hs_out_valid", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hw2_result_collector.md
HW2_RESULT_COLLECTOR -- requirements
Module: hw2_result_collector

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width; the result width is 2*WIDTH.
REQ-002 The block SHALL have parameter FRAME_LEN, default 16, giving the samples per report frame; legal range is 1..255.
REQ-003 The block SHALL use one clock; reset is synchronous and active-low.
REQ-004 clk  input  1  clock; all state changes on posedge.
REQ-005 rst  input  1  synchronous active-low reset.
REQ-006 in_valid  input  1  upstream sample present.
REQ-007 in_ready  output  1  block can accept a sample.
REQ-008 a, b, c  input  WIDTH each  operands applied to the upstream datapath.
REQ-009 s  input  1  1 = add, 0 = subtract.
REQ-010 d  input  2*WIDTH  datapath result under check.
REQ-011 flush  input  1  close the current frame early.
REQ-012 out_valid  output  1  frame report available.
REQ-013 out_ready  input  1  consumer takes the report.
REQ-014 out_count  output  8  samples in the reported frame.
REQ-015 out_sum  output  2*WIDTH+8  sum of accepted d values, modulo 2^(2*WIDTH+8).
REQ-016 out_err_cnt  output  8  mismatching samples in the frame.
REQ-017 out_first_err  output  8  0-based index of the first mismatch; 8'hFF if there is none.
REQ-018 busy  output  1  high in COLLECT or REPORT.

Function
REQ-019 The FSM SHALL have three states: IDLE, COLLECT and REPORT.
REQ-020 A sample SHALL be accepted in any cycle where in_valid && in_ready at posedge.
REQ-021 in_ready SHALL be 1 in IDLE and COLLECT, and 0 in REPORT; in_valid in REPORT SHALL be ignored.
REQ-022 The expected value SHALL be ((s ? a+b : a-b) * c) mod 2^(2*WIDTH), with a-b computed two's-complement at 2*WIDTH bits; for example, (0-1)*1 = 65535 for WIDTH=8.
REQ-023 On each accept the block SHALL update its state as follows:
- count += 1;
- sum += d (wraps);
- if d != expected, err_cnt += 1;
- if d != expected and no earlier mismatch has occurred in the frame, first_err = the pre-increment count.
REQ-024 IDLE -> COLLECT SHALL occur on the first accept, and that sample SHALL be counted.
REQ-025 COLLECT -> REPORT SHALL occur on the accept that makes count == FRAME_LEN.
REQ-026 COLLECT -> REPORT SHALL also occur when flush=1; if flush coincides with an accept, that sample SHALL be included.
REQ-027 If FRAME_LEN=1, the first accept SHALL go IDLE -> REPORT directly.
REQ-028 flush in IDLE or REPORT SHALL be ignored.
REQ-029 out_valid SHALL be registered and asserted the cycle after the closing accept or flush; report latency is 1 cycle.
REQ-030 While out_valid=1 && out_ready=0, all out_* fields SHALL hold stable.
REQ-031 On out_valid && out_ready, the block SHALL return to IDLE next cycle.
REQ-032 On that same handshake, the internal count, sum and err_cnt SHALL clear to 0 and first_err SHALL clear to 8'hFF.
REQ-033 out_* fields SHALL be valid only while out_valid=1; they SHALL present the frame totals captured at the transition into REPORT.

Reset
REQ-034 When rst=0 at posedge, the state SHALL be IDLE, out_valid=0, busy=0, and internal count, sum and err_cnt SHALL be 0.
REQ-035 When rst=0 at posedge, out_count, out_sum and out_err_cnt SHALL be 0, and out_first_err SHALL be 8'hFF.
REQ-036 Reset SHALL take priority over accept, flush and the out handshake in the same cycle.
REQ-037 Reset mid-frame SHALL discard the partial frame with no report.
REQ-038 in_ready SHALL be 1 from the first cycle after reset.

Verification (WIDTH=8, FRAME_LEN=4)
REQ-039 Reset scenario: rst=0 for 2 cycles -> in_ready=1, out_valid=0, busy=0, out_first_err=8'hFF.
REQ-040 Clean frame scenario: send (3+5)*7 with d=56, (10-4)*2 with d=12, (0-1)*1 with d=65535, and (255+255)*255 with d=64514 -> one cycle later out_valid=1, out_count=4, out_sum=130117, out_err_cnt=0, out_first_err=255.
REQ-041 Mismatch scenario: same frame with the second sample at d=13 -> out_err_cnt=1, out_first_err=1, out_sum=130118.
REQ-042 Backpressure scenario: hold out_ready=0 for 5 cycles in REPORT while in_valid=1 -> out_* fields stable, in_ready=0, no sample counted; out_ready=1 -> IDLE next cycle, and the next frame starts at count 0.
REQ-043 Flush scenario: two accepts, then flush=1 concurrent with a third accept -> out_count=3; flush in IDLE -> no out_valid.
REQ-044 Reset mid-frame scenario: three accepts, then rst=0 for 1 cycle -> no report; the following four accepts report out_count=4.
